// File: rtl/mac_package.sv
// mac_package: shared types, sizes and FSM encoding for the MAC engine controller.
`default_nettype none

package mac_package;

    localparam int MAC_CNT_LEN = 256;
    localparam int MAC_CNT_W   = $clog2(MAC_CNT_LEN) + 1;

    typedef struct packed {
        logic                 clear;
        logic                 enable;
        logic                 start;
        logic                 simple_mul;
        logic [5:0]           shift;
        logic [MAC_CNT_W-1:0] len;
    } ctrl_engine_t;

    typedef struct packed {
        logic [MAC_CNT_W-1:0] cnt;
        logic                 acc_done;
    } flags_engine_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_START   = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_NEXT    = 3'd4,
        ST_DONE    = 3'd5
    } mac_ctrl_state_e;

endpackage

`default_nettype wire

// File: rtl/mac_ctrl_wdog.sv
// mac_ctrl_wdog: progress watchdog; trips after WDOG_CYCLES consecutive idle cycles while running.
`default_nettype none

module mac_ctrl_wdog #(
    parameter int WDOG_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic restart_i,
    input  logic run_i,
    input  logic kick_i,
    output logic trip_o
);

    localparam int CNT_W = $clog2(WDOG_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i || kick_i || !run_i) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Trip on the cycle that would bring the count to WDOG_CYCLES.
    assign trip_o = run_i & ~kick_i & ~restart_i & (cnt_q == CNT_W'(WDOG_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mac_engine_ctrl.sv
// mac_engine_ctrl: job sequencer for the MAC engine (clear/start/compute per iteration).
// Optional progress watchdog enabled by defining MAC_CTRL_WATCHDOG_EN.
`default_nettype none

module mac_engine_ctrl
    import mac_package::*;
#(
    parameter int ITER_W      = 16,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 test_mode_i,
    input  logic                 clear_i,
    input  logic                 job_valid_i,
    output logic                 job_ready_o,
    input  logic [MAC_CNT_W-1:0] job_len_i,
    input  logic [5:0]           job_shift_i,
    input  logic                 job_simple_mul_i,
    input  logic [ITER_W-1:0]    job_nb_iter_i,
    output ctrl_engine_t         engine_ctrl_o,
    input  flags_engine_t        engine_flags_i,
    input  logic                 d_hs_i,
    output logic                 stream_req_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [ITER_W-1:0]    iter_o,
    output logic                 err_o
);

    mac_ctrl_state_e      state_q, state_d;
    logic [ITER_W-1:0]    iter_q, iter_d, nb_iter_q, nb_iter_d, iter_inc;
    logic [MAC_CNT_W-1:0] len_q, len_d, prod_q, prod_d, prod_inc;
    logic [5:0]           shift_q, shift_d;
    logic                 simple_q, simple_d;
    logic                 err_q, err_d;
    logic                 in_compute;
    logic                 wdog_trip;
    logic                 unused_ok;

    assign in_compute = (state_q == ST_COMPUTE);
    assign iter_inc   = iter_q + 1'b1;
    assign prod_inc   = prod_q + 1'b1;
    assign unused_ok  = ^{test_mode_i, engine_flags_i.cnt};

`ifdef MAC_CTRL_WATCHDOG_EN
    mac_ctrl_wdog #(
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_wdog (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .restart_i (clear_i),
        .run_i     (in_compute),
        .kick_i    (d_hs_i | engine_flags_i.acc_done),
        .trip_o    (wdog_trip)
    );
`else
    logic unused_wdog;
    assign unused_wdog = (WDOG_CYCLES == 0);
    assign wdog_trip   = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        iter_d    = iter_q;
        nb_iter_d = nb_iter_q;
        len_d     = len_q;
        prod_d    = prod_q;
        shift_d   = shift_q;
        simple_d  = simple_q;
        err_d     = err_q;
        if (clear_i) begin
            state_d = ST_IDLE;
            iter_d  = '0;
            prod_d  = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (job_valid_i) begin
                        nb_iter_d = job_nb_iter_i;
                        len_d     = job_len_i;
                        shift_d   = job_shift_i;
                        simple_d  = job_simple_mul_i;
                        iter_d    = '0;
                        prod_d    = '0;
                        // Degenerate jobs finish without touching the engine.
                        state_d   = ((job_nb_iter_i == '0) || (job_len_i == '0)) ? ST_DONE : ST_CLEAR;
                    end
                end
                ST_CLEAR: state_d = ST_START;
                ST_START: state_d = ST_COMPUTE;
                ST_COMPUTE: begin
                    if (wdog_trip) begin
                        err_d   = 1'b1;
                        prod_d  = '0;
                        state_d = ST_DONE;
                    end else if (simple_q) begin
                        if (d_hs_i) begin
                            if (prod_inc == len_q) begin
                                prod_d  = '0;
                                state_d = ST_NEXT;
                            end else begin
                                prod_d = prod_inc;
                            end
                        end
                    end else if (engine_flags_i.acc_done) begin
                        state_d = ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    iter_d  = iter_inc;
                    state_d = (iter_inc == nb_iter_q) ? ST_DONE : ST_CLEAR;
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            iter_q    <= '0;
            nb_iter_q <= '0;
            len_q     <= '0;
            prod_q    <= '0;
            shift_q   <= '0;
            simple_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            iter_q    <= iter_d;
            nb_iter_q <= nb_iter_d;
            len_q     <= len_d;
            prod_q    <= prod_d;
            shift_q   <= shift_d;
            simple_q  <= simple_d;
            err_q     <= err_d;
        end
    end

    assign job_ready_o              = rst_ni & (state_q == ST_IDLE) & ~clear_i;
    assign engine_ctrl_o.clear      = clear_i | (state_q == ST_CLEAR) | wdog_trip;
    assign engine_ctrl_o.enable     = (state_q != ST_IDLE);
    assign engine_ctrl_o.start      = (state_q == ST_START);
    assign engine_ctrl_o.simple_mul = simple_q;
    assign engine_ctrl_o.shift      = shift_q;
    assign engine_ctrl_o.len        = len_q;
    assign stream_req_o             = (state_q == ST_START);
    assign busy_o                   = (state_q != ST_IDLE);
    assign done_o                   = (state_q == ST_DONE) & ~clear_i;
    assign iter_o                   = iter_q;
    assign err_o                    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_engine_ctrl.sv
// tb_mac_engine_ctrl: directed self-checking bench for mac_engine_ctrl.
`default_nettype none

module tb_mac_engine_ctrl;
    import mac_package::*;

    localparam int ITER_W = 16;

    logic                 clk;
    logic                 rst_ni;
    logic                 test_mode;
    logic                 clear;
    logic                 job_valid;
    logic                 job_ready;
    logic [MAC_CNT_W-1:0] job_len;
    logic [5:0]           job_shift;
    logic                 job_simple;
    logic [ITER_W-1:0]    job_nb_iter;
    ctrl_engine_t         eng;
    flags_engine_t        flags;
    logic                 acc_done;
    logic                 d_hs;
    logic                 stream_req;
    logic                 busy;
    logic                 done;
    logic [ITER_W-1:0]    iter;
    logic                 err;

    int errors = 0;
    int checks = 0;

    assign flags = {{MAC_CNT_W{1'b0}}, acc_done};

    mac_engine_ctrl #(
        .ITER_W      (ITER_W),
        .WDOG_CYCLES (16)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .test_mode_i      (test_mode),
        .clear_i          (clear),
        .job_valid_i      (job_valid),
        .job_ready_o      (job_ready),
        .job_len_i        (job_len),
        .job_shift_i      (job_shift),
        .job_simple_mul_i (job_simple),
        .job_nb_iter_i    (job_nb_iter),
        .engine_ctrl_o    (eng),
        .engine_flags_i   (flags),
        .d_hs_i           (d_hs),
        .stream_req_o     (stream_req),
        .busy_o           (busy),
        .done_o           (done),
        .iter_o           (iter),
        .err_o            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_job(input logic [MAC_CNT_W-1:0] len, input logic [5:0] sh,
                             input logic simple, input logic [ITER_W-1:0] nb);
        job_len     = len;
        job_shift   = sh;
        job_simple  = simple;
        job_nb_iter = nb;
        job_valid   = 1'b1;
        #1;
        checks++; if (job_ready !== 1'b1) begin errors++; $display("FAIL job_ready_idle: got %b want 1", job_ready); end
        step();
        job_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        step();
        step();
        checks++; if (eng !== '0) begin errors++; $display("FAIL reset_engine_ctrl: got %h want 0", eng); end
        checks++; if (stream_req !== 1'b0) begin errors++; $display("FAIL reset_stream_req: got %b want 0", stream_req); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
        checks++; if (iter !== '0 || err !== 1'b0) begin errors++; $display("FAIL reset_iter_err: got %0d/%b want 0/0", iter, err); end
        checks++; if (job_ready !== 1'b0) begin errors++; $display("FAIL reset_job_ready: got %b want 0", job_ready); end
        rst_ni = 1'b1;
        #1;
        checks++; if (job_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", job_ready); end
    endtask

    task automatic test_scalar();
        issue_job(9'd4, 6'd5, 1'b0, 16'd2);
        // CLEAR
        checks++; if (eng.clear !== 1'b1 || eng.enable !== 1'b1 || eng.start !== 1'b0) begin errors++; $display("FAIL scalar_clear: got c%b e%b s%b want c1 e1 s0", eng.clear, eng.enable, eng.start); end
        checks++; if (eng.shift !== 6'd5 || eng.len !== 9'd4 || eng.simple_mul !== 1'b0) begin errors++; $display("FAIL scalar_fields: got sh%0d len%0d sm%b want sh5 len4 sm0", eng.shift, eng.len, eng.simple_mul); end
        checks++; if (busy !== 1'b1 || job_ready !== 1'b0) begin errors++; $display("FAIL scalar_busy: got busy%b rdy%b want busy1 rdy0", busy, job_ready); end
        step(); // START
        checks++; if (eng.start !== 1'b1 || stream_req !== 1'b1 || eng.clear !== 1'b0) begin errors++; $display("FAIL scalar_start1: got s%b sr%b c%b want s1 sr1 c0", eng.start, stream_req, eng.clear); end
        step(); // COMPUTE
        checks++; if (eng.start !== 1'b0 || stream_req !== 1'b0) begin errors++; $display("FAIL scalar_compute: got s%b sr%b want 0 0", eng.start, stream_req); end
        step();
        step();
        acc_done = 1'b1;
        step(); // NEXT
        acc_done = 1'b0;
        checks++; if (iter !== 16'd0 || done !== 1'b0) begin errors++; $display("FAIL scalar_next1: got iter%0d done%b want iter0 done0", iter, done); end
        step(); // CLEAR, iteration 1
        checks++; if (iter !== 16'd1 || eng.clear !== 1'b1) begin errors++; $display("FAIL scalar_iter1: got iter%0d clr%b want iter1 clr1", iter, eng.clear); end
        step(); // START
        checks++; if (stream_req !== 1'b1) begin errors++; $display("FAIL scalar_start2: got %b want 1", stream_req); end
        step(); // COMPUTE
        acc_done = 1'b1;
        step(); // NEXT
        acc_done = 1'b0;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL scalar_no_early_done: got %b want 0", done); end
        step(); // DONE
        checks++; if (done !== 1'b1 || iter !== 16'd2) begin errors++; $display("FAIL scalar_done: got done%b iter%0d want done1 iter2", done, iter); end
        step(); // IDLE
        checks++; if (done !== 1'b0 || busy !== 1'b0 || iter !== 16'd2) begin errors++; $display("FAIL scalar_idle: got done%b busy%b iter%0d want 0 0 2", done, busy, iter); end
    endtask

    task automatic test_simple_mul();
        issue_job(9'd3, 6'd0, 1'b1, 16'd1);
        checks++; if (eng.simple_mul !== 1'b1) begin errors++; $display("FAIL simple_flag: got %b want 1", eng.simple_mul); end
        step(); // START: handshake here must be ignored
        d_hs = 1'b1;
        step(); // COMPUTE
        d_hs = 1'b1;
        step();
        d_hs = 1'b0;
        step();
        d_hs = 1'b1;
        step();
        d_hs = 1'b0;
        step();
        checks++; if (done !== 1'b0 || iter !== 16'd0 || busy !== 1'b1) begin errors++; $display("FAIL simple_two_pulses: got done%b iter%0d busy%b want 0 0 1", done, iter, busy); end
        d_hs = 1'b1;
        step(); // NEXT
        d_hs = 1'b0;
        checks++; if (done !== 1'b0 || iter !== 16'd0) begin errors++; $display("FAIL simple_next: got done%b iter%0d want 0 0", done, iter); end
        step(); // DONE
        checks++; if (done !== 1'b1 || iter !== 16'd1) begin errors++; $display("FAIL simple_done: got done%b iter%0d want 1 1", done, iter); end
        step();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL simple_idle: got busy%b done%b want 0 0", busy, done); end
    endtask

    task automatic test_zero_job();
        issue_job(9'd4, 6'd1, 1'b0, 16'd0);
        checks++; if (done !== 1'b1 || eng.start !== 1'b0 || stream_req !== 1'b0 || eng.clear !== 1'b0) begin errors++; $display("FAIL zero_iter: got done%b s%b sr%b c%b want 1 0 0 0", done, eng.start, stream_req, eng.clear); end
        step();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_iter_idle: got done%b busy%b want 0 0", done, busy); end
        issue_job(9'd0, 6'd1, 1'b1, 16'd3);
        checks++; if (done !== 1'b1 || stream_req !== 1'b0) begin errors++; $display("FAIL zero_len: got done%b sr%b want 1 0", done, stream_req); end
        step();
    endtask

    task automatic test_clear();
        issue_job(9'd2, 6'd3, 1'b0, 16'd3);
        step(); // START
        step(); // COMPUTE
        acc_done = 1'b1;
        step(); // NEXT
        acc_done = 1'b0;
        step(); // CLEAR
        step(); // START
        step(); // COMPUTE, iteration 1
        clear = 1'b1;
        acc_done = 1'b1;
        #1;
        checks++; if (eng.clear !== 1'b1 || done !== 1'b0 || job_ready !== 1'b0) begin errors++; $display("FAIL clear_same_cycle: got c%b done%b rdy%b want 1 0 0", eng.clear, done, job_ready); end
        step();
        acc_done = 1'b0;
        checks++; if (busy !== 1'b0 || iter !== 16'd0 || done !== 1'b0) begin errors++; $display("FAIL clear_idle: got busy%b iter%0d done%b want 0 0 0", busy, iter, done); end
        // clear beats a simultaneous handshake
        job_valid = 1'b1;
        job_nb_iter = 16'd1;
        job_len = 9'd1;
        #1;
        checks++; if (job_ready !== 1'b0) begin errors++; $display("FAIL clear_ready: got %b want 0", job_ready); end
        step();
        job_valid = 1'b0;
        clear = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_blocks_job: got busy%b want 0", busy); end
        issue_job(9'd1, 6'd2, 1'b0, 16'd1);
        checks++; if (eng.clear !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL clear_new_job: got c%b busy%b want 1 1", eng.clear, busy); end
        step();
        step();
        acc_done = 1'b1;
        step();
        acc_done = 1'b0;
        step();
        checks++; if (done !== 1'b1 || iter !== 16'd1) begin errors++; $display("FAIL clear_new_done: got done%b iter%0d want 1 1", done, iter); end
        step();
    endtask

    task automatic test_reset_mid();
        issue_job(9'd4, 6'd7, 1'b1, 16'd2);
        step();
        step(); // COMPUTE
        rst_ni = 1'b0;
        #1;
        checks++; if (job_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b want 0", job_ready); end
        step();
        checks++; if (eng !== '0 || busy !== 1'b0 || done !== 1'b0 || stream_req !== 1'b0 || iter !== '0 || err !== 1'b0) begin errors++; $display("FAIL midrst_outputs: got eng%h busy%b done%b sr%b iter%0d err%b want all 0", eng, busy, done, stream_req, iter, err); end
        rst_ni = 1'b1;
        step();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_after: got done%b busy%b want 0 0", done, busy); end
    endtask

`ifdef MAC_CTRL_WATCHDOG_EN
    task automatic test_watchdog();
        issue_job(9'd4, 6'd0, 1'b0, 16'd1);
        step();
        step(); // COMPUTE cycle 1
        for (int i = 0; i < 15; i++) begin
            checks++; if (err !== 1'b0 || eng.clear !== 1'b0) begin errors++; $display("FAIL wdog_early_%0d: got err%b c%b want 0 0", i, err, eng.clear); end
            step();
        end
        checks++; if (eng.clear !== 1'b1) begin errors++; $display("FAIL wdog_clear_pulse: got %b want 1", eng.clear); end
        step(); // DONE
        checks++; if (err !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL wdog_trip: got err%b done%b want 1 1", err, done); end
        step();
        step();
        checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL wdog_sticky: got err%b busy%b want 1 0", err, busy); end
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL wdog_cleared: got %b want 0", err); end
    endtask
`endif

    initial begin
        rst_ni      = 1'b0;
        test_mode   = 1'b0;
        clear       = 1'b0;
        job_valid   = 1'b0;
        job_len     = '0;
        job_shift   = '0;
        job_simple  = 1'b0;
        job_nb_iter = '0;
        acc_done    = 1'b0;
        d_hs        = 1'b0;
        test_reset();
        test_scalar();
        test_simple_mul();
        test_zero_job();
        test_clear();
        test_reset_mid();
`ifdef MAC_CTRL_WATCHDOG_EN
        test_watchdog();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mac_engine_ctrl.md
MAC_ENGINE_CTRL -- requirements
Module: mac_engine_ctrl

Interface
REQ-001 SHALL have parameter ITER_W, default 16, width of the iteration count and index.
REQ-002 SHALL have parameter WDOG_CYCLES, default 1024, watchdog limit; used only under MAC_CTRL_WATCHDOG_EN.
REQ-003 SHALL have ports: clk_i  in  1  sole clock, rising edge.
REQ-004 rst_ni  in  1  reset, synchronous, active-low.
REQ-005 test_mode_i  in  1  test mode; no functional effect.
REQ-006 clear_i  in  1  soft clear.
REQ-007 job_valid_i / job_ready_o  in/out  1/1  job descriptor handshake.
REQ-008 job_len_i  in  $clog2(MAC_CNT_LEN)+1  products per iteration.
REQ-009 job_shift_i  in  6  engine shift amount.
REQ-010 job_simple_mul_i  in  1  1 = simple-multiply mode, 0 = scalar-product mode.
REQ-011 job_nb_iter_i  in  ITER_W  number of iterations.
REQ-012 engine_ctrl_o  out  ctrl_engine_t  clear, enable, start, simple_mul, shift, len to the MAC engine.
REQ-013 engine_flags_i  in  flags_engine_t  cnt and acc_done from the MAC engine.
REQ-014 d_hs_i  in  1  engine output stream handshake (valid & ready).
REQ-015 stream_req_o  out  1  one-cycle streamer start pulse per iteration.
REQ-016 busy_o / done_o / iter_o / err_o  out  1/1/ITER_W/1  busy; one-cycle done pulse; current iteration index; sticky watchdog error.

Function
REQ-017 SHALL implement the FSM IDLE -> CLEAR -> START -> COMPUTE -> NEXT -> (CLEAR | DONE) -> IDLE.
REQ-018 job_ready_o SHALL equal (state==IDLE) & ~clear_i; all job fields SHALL be latched on the handshake.
REQ-019 Job accepted in cycle t SHALL give CLEAR at t+1 (engine clear=1) and START at t+2 (engine start=1, stream_req_o=1); COMPUTE SHALL follow from t+3.
REQ-020 engine enable SHALL be 1 in every state except IDLE; shift, len and simple_mul SHALL be driven from the latched job.
REQ-021 In scalar mode, COMPUTE SHALL exit to NEXT on the cycle after engine_flags_i.acc_done=1.
REQ-022 In simple-multiply mode, COMPUTE SHALL count d_hs_i pulses and exit to NEXT after the job_len-th pulse.
REQ-023 NEXT SHALL increment iter_o, then go to DONE if the new value equals nb_iter, else to CLEAR.
REQ-024 DONE SHALL assert done_o for exactly one cycle, then return to IDLE; iter_o SHALL hold its final value until the next job is accepted, which resets it to 0.
REQ-025 A job with nb_iter=0 or len=0 SHALL go IDLE -> DONE directly, with no clear, start or stream_req_o pulse (done_o at t+1).
REQ-026 busy_o SHALL be 1 in every state except IDLE.
REQ-027 clear_i SHALL return the FSM to IDLE the next cycle, assert engine clear in the same cycle, zero iter_o and the product counter, and never pulse done_o.
REQ-028 clear_i SHALL have priority over all other events, including a simultaneous job handshake, acc_done or d_hs_i.
REQ-029 d_hs_i and acc_done SHALL be ignored outside COMPUTE.

Reset
REQ-030 With rst_ni=0 at a clock edge: state=IDLE, engine_ctrl_o all zero, stream_req_o=0, busy_o=0, done_o=0, iter_o=0, err_o=0, counters zero.
REQ-031 Reset in mid-operation SHALL abort the job with no done_o pulse; job_ready_o SHALL be 0 while rst_ni=0.

Configuration
REQ-032 With MAC_CTRL_WATCHDOG_EN defined: a counter SHALL clear on entry to COMPUTE and on each d_hs_i or acc_done, and increment otherwise in COMPUTE.
REQ-033 When that counter reaches WDOG_CYCLES: err_o SHALL set (sticky until clear_i or reset), engine clear SHALL be pulsed, and the FSM SHALL go to DONE.
REQ-034 Without MAC_CTRL_WATCHDOG_EN: no watchdog counter, err_o tied to 0, and COMPUTE waits indefinitely.

Structure
REQ-035 ctrl_engine_t, flags_engine_t, MAC_CNT_LEN and the FSM state enum SHALL live in mac_package.
REQ-036 The watchdog SHALL be the sub-module mac_ctrl_wdog, instantiated only under MAC_CTRL_WATCHDOG_EN.

Verification
REQ-037 Scalar job len=4, nb_iter=2, acc_done in each iteration -> two start pulses, iter_o 0->1->2, one done_o after the second acc_done.
REQ-038 Simple-mul job len=3, nb_iter=1, three d_hs_i pulses -> NEXT after the third pulse, done_o pulse, busy_o falls.
REQ-039 Job nb_iter=0 -> done_o at t+1, no engine start and no stream_req_o pulse.
REQ-040 clear_i in COMPUTE of iteration 1 of 3 -> IDLE next cycle, engine clear=1, no done_o, new job accepted afterwards.
REQ-041 rst_ni=0 for one cycle mid-job -> all outputs at reset values at the following edge.
REQ-042 With the macro defined, WDOG_CYCLES=16 and no progress -> err_o=1 after 16 COMPUTE cycles, done_o pulse, err_o held until clear_i.
